calc_controller: RTL and testbench
==================================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have ports, clock and reset first: clock  in  1  single system clock, all logic on posedge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have key_valid  in  1  one-cycle pulse marking key_code valid.
REQ-004 SHALL have key_code  in  4  0-9 digit; A add; B subtract; C multiply; D divide; E equals; F clear.
REQ-005 SHALL have regA, regB  out  11 each, signed  ALU operands.
REQ-006 SHALL have opcode  out  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have computestrobe  out  1  one-cycle ALU start pulse.
REQ-008 SHALL have alu_result  in  21 signed, alu_remain  in  1, alu_remainder  in  21  from ALU.
REQ-009 SHALL have disp_value  out  21 signed, disp_remainder  out  21, disp_rem_valid  out  1  display data.
REQ-010 SHALL have busy  out  1  high in COMPUTE/WAIT; err  out  1  high in ERROR.

Function
REQ-011 SHALL implement states ENTER_A, ENTER_B, COMPUTE, WAIT, SHOW, ERROR.
REQ-012 Digit in ENTER_A/ENTER_B: acc = acc*10 + digit; SHALL ignore a 4th digit (operand max 999).
REQ-013 ENTER_A, op key (A-D): regA <= acc, opcode latched, acc and digit count cleared, -> ENTER_B; equals ignored.
REQ-014 ENTER_B, op key with zero B digits: SHALL replace opcode; with digits entered: ignored.
REQ-015 ENTER_B, equals with at least one B digit: regB <= acc, -> COMPUTE; with zero digits: ignored.
REQ-016 COMPUTE: computestrobe SHALL be high exactly one cycle, regA/regB/opcode stable; -> WAIT.
REQ-017 WAIT: one cycle; at its closing edge SHALL capture alu_result to disp_value, alu_remainder to disp_remainder, alu_remain to disp_rem_valid; -> SHOW.
REQ-018 In ENTER_A/ENTER_B, disp_value SHALL show acc, zero-extended; disp_rem_valid SHALL be 0.
REQ-019 SHOW, digit: SHALL start a new ENTER_A with acc = digit.
REQ-020 SHOW, op key: if -999 <= result <= 999, regA <= result (chaining), opcode latched, -> ENTER_B; else -> ERROR.
REQ-021 SHOW, equals: ignored.
REQ-022 ERROR: all keys except clear ignored; err high.
REQ-023 Clear in any state, including COMPUTE/WAIT: -> ENTER_A next cycle; acc, regA, regB, display outputs zeroed; any pending ALU result discarded.
REQ-024 Non-clear keys in COMPUTE/WAIT SHALL be ignored, not queued.
REQ-025 key_valid coincident with reset SHALL be ignored.

Reset
REQ-026 On reset: state ENTER_A; regA, regB, acc, digit count, opcode, disp_* = 0; computestrobe, busy, err = 0.
REQ-027 Reset SHALL take priority over every key, including mid-COMPUTE/WAIT.

Configuration
REQ-028 Macro DIV0_ERR_EN: when defined, equals in ENTER_B with opcode 11 and acc == 0 SHALL go directly to ERROR, with no computestrobe.
REQ-029 Without DIV0_ERR_EN: divide-by-zero SHALL compute normally and show disp_value 0, disp_rem_valid 0.

Structure
REQ-030 Shared package calc_pkg SHALL hold opcode constants, key codes, state enum typedef, MAX_OPERAND = 999, operand width 11, result width 21.
REQ-031 Sub-module calc_entry_acc SHALL hold the digit accumulator and count (clear, load, push digit, saturate at 3 digits).

Verification
REQ-032 Keys 1,2,A,3,4,E -> one computestrobe with regA=12, regB=34, opcode 00; disp_value 46 two cycles after strobe.
REQ-033 Keys 7,D,2,E -> disp_value 3, disp_remainder 1, disp_rem_valid 1.
REQ-034 Keys 5,B,8,E, then C,4,E -> disp_value -3, then regA=-3, regB=4 and disp_value -12.
REQ-035 Keys 9,9,9,C,9,9,9,E, then A -> disp_value 998001, then err=1; only F clears it.
REQ-036 Keys 1,2,3,4 -> acc 123; 7,D,0,E -> with DIV0_ERR_EN err=1 and no strobe; without it disp_value 0.
REQ-037 F in the WAIT cycle -> ENTER_A next cycle, disp_value 0, alu_result not captured.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the four-function calculator controller:
// widths, operand limits, key codes, ALU opcodes and the controller state type.
package calc_pkg;

    // Operand, result and entry-accumulator widths
    localparam int OPERAND_W   = 11;
    localparam int RESULT_W    = 21;
    localparam int ACC_W       = 10;
    localparam int CNT_W       = 2;
    localparam int MAX_OPERAND = 999;
    localparam int MAX_DIGITS  = 3;

    // ALU opcodes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Keypad codes; 0-9 are plain digits
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_ADD       = 4'hA;
    localparam logic [3:0] KEY_SUB       = 4'hB;
    localparam logic [3:0] KEY_MUL       = 4'hC;
    localparam logic [3:0] KEY_DIV       = 4'hD;
    localparam logic [3:0] KEY_EQ        = 4'hE;
    localparam logic [3:0] KEY_CLR       = 4'hF;

    // Controller states
    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_COMPUTE,
        ST_WAIT,
        ST_SHOW,
        ST_ERROR
    } state_t;

    // Operator keys A..D map in order onto opcodes 00..11
    function automatic logic [1:0] key_to_opcode(input logic [3:0] key);
        logic [3:0] diff;
        diff = key - KEY_ADD;
        return diff[1:0];
    endfunction

    // True for the four operator keys
    function automatic logic is_op_key(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

endpackage

// File: rtl/calc_entry_acc.sv
// Decimal digit-entry accumulator: holds the operand being typed and how many
// digits it has. Digits beyond the third are dropped so the value never
// exceeds 999. Priority: clear, then load (start fresh with one digit), then push.
module calc_entry_acc
    import calc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count
);

    // acc*10 + digit; with at most two digits held the sum stays below 1000
    logic [ACC_W+3:0] pushed_wide;
    logic             has_room;

    assign pushed_wide = acc * 4'd10 + digit;
    assign has_room    = (count < CNT_W'(MAX_DIGITS));

    // Accumulator and digit count update
    always_ff @(posedge clock) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (reset || clear) begin
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= ACC_W'(digit);
            count <= CNT_W'(1);
        end else if (push && has_room) begin
            acc   <= pushed_wide[ACC_W-1:0];
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad-driven calculator controller. Collects two decimal operands and an
// operator, launches an external ALU with a one-cycle strobe, captures the
// result one cycle later and supports chaining the result into the next
// operation. Results outside +/-999 cannot be chained and raise an error.
// Optional build macro DIV0_ERR_EN: when defined, equals with a zero divisor
// goes straight to the error state without starting the ALU.
module calc_controller
    import calc_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [3:0]                 key_code,
    output logic signed [OPERAND_W-1:0] regA,
    output logic signed [OPERAND_W-1:0] regB,
    output logic [1:0]                 opcode,
    output logic                       computestrobe,
    input  logic signed [RESULT_W-1:0] alu_result,
    input  logic                       alu_remain,
    input  logic [RESULT_W-1:0]        alu_remainder,
    output logic signed [RESULT_W-1:0] disp_value,
    output logic [RESULT_W-1:0]        disp_remainder,
    output logic                       disp_rem_valid,
    output logic                       busy,
    output logic                       err
);

    localparam logic signed [RESULT_W-1:0] RES_MAX = RESULT_W'(MAX_OPERAND);
    localparam logic signed [RESULT_W-1:0] RES_MIN = -RES_MAX;

    state_t state, next_state;

    // Decoded key events
    logic is_clr, is_digit, is_op, is_eq;
    assign is_clr   = key_valid && (key_code == KEY_CLR);
    assign is_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign is_op    = key_valid && is_op_key(key_code);
    assign is_eq    = key_valid && (key_code == KEY_EQ);

    // Entry accumulator
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             acc_clear, acc_load, acc_push;
    logic             has_b;
    assign has_b = (count != '0);

    calc_entry_acc u_entry_acc (
        .clock (clock),
        .reset (reset),
        .clear (acc_clear),
        .load  (acc_load),
        .push  (acc_push),
        .digit (key_code),
        .acc   (acc),
        .count (count)
    );

    // Captured ALU outputs, shown outside the entry states
    logic signed [RESULT_W-1:0] res_q;
    logic [RESULT_W-1:0]        rem_q;
    logic                       rem_valid_q;
    logic                       res_in_range;
    assign res_in_range = (res_q >= RES_MIN) && (res_q <= RES_MAX);

`ifdef DIV0_ERR_EN
    logic div_by_zero;
    assign div_by_zero = (opcode == OP_DIV) && (acc == '0);
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_ENTER_A;
        else       state <= next_state;
    end

    // Next-state decode; clear overrides everything including COMPUTE/WAIT
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        if (is_clr) begin
            next_state = ST_ENTER_A;
        end else begin
            unique case (state)
                ST_ENTER_A: if (is_op) next_state = ST_ENTER_B;
                ST_ENTER_B: begin
                    if (is_eq && has_b) begin
`ifdef DIV0_ERR_EN
                        next_state = div_by_zero ? ST_ERROR : ST_COMPUTE;
`else
                        next_state = ST_COMPUTE;
`endif
                    end
                end
                ST_COMPUTE: next_state = ST_WAIT;
                ST_WAIT:    next_state = ST_SHOW;
                ST_SHOW: begin
                    if (is_digit)   next_state = ST_ENTER_A;
                    else if (is_op) next_state = res_in_range ? ST_ENTER_B : ST_ERROR;
                end
                ST_ERROR:   next_state = ST_ERROR;
                default:    next_state = ST_ENTER_A;
            endcase
        end
    end

    // Accumulator control: fresh operand after each operator/equals, digit restart from SHOW
    always_comb begin
        acc_clear = is_clr
                 || ((state == ST_ENTER_A) && is_op)
                 || ((state == ST_ENTER_B) && is_eq && has_b)
                 || ((state == ST_SHOW) && is_op);
        acc_load  = (state == ST_SHOW) && is_digit;
        acc_push  = ((state == ST_ENTER_A) || (state == ST_ENTER_B)) && is_digit;
    end

    // Operand, opcode and result registers
    always_ff @(posedge clock) begin
        if (reset || is_clr) begin
            regA        <= '0;
            regB        <= '0;
            opcode      <= OP_ADD;
            res_q       <= '0;
            rem_q       <= '0;
            rem_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_ENTER_A: begin
                    if (is_op) begin
                        regA   <= {1'b0, acc};
                        opcode <= key_to_opcode(key_code);
                    end
                end
                ST_ENTER_B: begin
                    if (is_op && !has_b) opcode <= key_to_opcode(key_code);
                    if (is_eq && has_b)  regB   <= {1'b0, acc};
                end
                ST_WAIT: begin
                    res_q       <= alu_result;
                    rem_q       <= alu_remainder;
                    rem_valid_q <= alu_remain;
                end
                ST_SHOW: begin
                    if (is_op && res_in_range) begin
                        regA   <= res_q[OPERAND_W-1:0];
                        opcode <= key_to_opcode(key_code);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs: strobe/busy/err from state, display muxes acc or captured result
    always_comb begin
        computestrobe  = (state == ST_COMPUTE);
        busy           = (state == ST_COMPUTE) || (state == ST_WAIT);
        err            = (state == ST_ERROR);
        disp_value     = res_q;
        disp_remainder = rem_q;
        disp_rem_valid = rem_valid_q;
        if ((state == ST_ENTER_A) || (state == ST_ENTER_B)) begin
            disp_value     = RESULT_W'(acc);
            disp_remainder = '0;
            disp_rem_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: a key/expected-display table plus
// hand-written sequences for strobe timing, chaining, clear/reset during a
// computation and divide-by-zero (both DIV0_ERR_EN builds).
module tb_calc_controller;
    import calc_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic                key_valid;
    logic [3:0]          key_code;
    logic signed [10:0]  regA, regB;
    logic [1:0]          opcode;
    logic                computestrobe;
    logic signed [20:0]  alu_result;
    logic                alu_remain;
    logic [20:0]         alu_remainder;
    logic signed [20:0]  disp_value;
    logic [20:0]         disp_remainder;
    logic                disp_rem_valid;
    logic                busy;
    logic                err;

    int total = 0;
    int bad   = 0;

    calc_controller dut (
        .clock          (clock),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .regA           (regA),
        .regB           (regB),
        .opcode         (opcode),
        .computestrobe  (computestrobe),
        .alu_result     (alu_result),
        .alu_remain     (alu_remain),
        .alu_remainder  (alu_remainder),
        .disp_value     (disp_value),
        .disp_remainder (disp_remainder),
        .disp_rem_valid (disp_rem_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    // External ALU stand-in: registers its result on the strobe edge
    int strobe_count = 0;
    int cap_a, cap_b, cap_op;
    int alu_a, alu_b, alu_r, alu_m;
    initial begin
        alu_result    = '0;
        alu_remain    = 1'b0;
        alu_remainder = '0;
    end
    always @(posedge clock) begin
        if (computestrobe) begin
            alu_a = int'(regA);
            alu_b = int'(regB);
            alu_m = 0;
            case (opcode)
                2'b00:   alu_r = alu_a + alu_b;
                2'b01:   alu_r = alu_a - alu_b;
                2'b10:   alu_r = alu_a * alu_b;
                default: begin
                    if (alu_b == 0) alu_r = 0;
                    else begin
                        alu_r = alu_a / alu_b;
                        alu_m = alu_a % alu_b;
                    end
                end
            endcase
            alu_result    <= alu_r[20:0];
            alu_remainder <= alu_m[20:0];
            alu_remain    <= (alu_m != 0);
            strobe_count  <= strobe_count + 1;
            cap_a         <= alu_a;
            cap_b         <= alu_b;
            cap_op        <= int'(opcode);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (n >= 10) check("settle_timeout", 1, 0);
    endtask

    typedef struct {
        logic [3:0] key;
        int         disp;
        int         rem;
        int         rv;
        int         er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] k, input int d, input int r, input int rv, input int e);
        vec_t v;
        v.key = k; v.disp = d; v.rem = r; v.rv = rv; v.er = e;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;

        // Basic add, divide with remainder, SHOW digit restart, SHOW equals ignored
        add(4'hF, 0, 0, 0, 0);
        add(4'h1, 1, 0, 0, 0);  add(4'h2, 12, 0, 0, 0); add(4'hA, 0, 0, 0, 0);
        add(4'h3, 3, 0, 0, 0);  add(4'h4, 34, 0, 0, 0); add(4'hE, 46, 0, 0, 0);
        add(4'h7, 7, 0, 0, 0);  add(4'hD, 0, 0, 0, 0);  add(4'h2, 2, 0, 0, 0);
        add(4'hE, 3, 1, 1, 0);
        add(4'hF, 0, 0, 0, 0);
        add(4'h5, 5, 0, 0, 0);  add(4'hB, 0, 0, 0, 0);  add(4'h8, 8, 0, 0, 0);
        add(4'hE, -3, 0, 0, 0); add(4'hC, 0, 0, 0, 0);  add(4'h4, 4, 0, 0, 0);
        add(4'hE, -12, 0, 0, 0); add(4'hE, -12, 0, 0, 0);
        // Equals ignored in ENTER_A and in ENTER_B with no digits
        add(4'hF, 0, 0, 0, 0);  add(4'h3, 3, 0, 0, 0);  add(4'hE, 3, 0, 0, 0);
        add(4'hA, 0, 0, 0, 0);  add(4'hE, 0, 0, 0, 0);  add(4'h1, 1, 0, 0, 0);
        add(4'hE, 4, 0, 0, 0);
        // Operator replacement with no B digits, operator ignored once B digits exist
        add(4'hF, 0, 0, 0, 0);  add(4'h6, 6, 0, 0, 0);  add(4'hA, 0, 0, 0, 0);
        add(4'hB, 0, 0, 0, 0);  add(4'h2, 2, 0, 0, 0);  add(4'hE, 4, 0, 0, 0);
        add(4'hF, 0, 0, 0, 0);  add(4'h8, 8, 0, 0, 0);  add(4'hA, 0, 0, 0, 0);
        add(4'h2, 2, 0, 0, 0);  add(4'hC, 2, 0, 0, 0);  add(4'hE, 10, 0, 0, 0);
        // 999*999, fourth digit ignored, chaining out of range -> error until clear
        add(4'hF, 0, 0, 0, 0);  add(4'h9, 9, 0, 0, 0);  add(4'h9, 99, 0, 0, 0);
        add(4'h9, 999, 0, 0, 0); add(4'h9, 999, 0, 0, 0); add(4'hC, 0, 0, 0, 0);
        add(4'h9, 9, 0, 0, 0);  add(4'h9, 99, 0, 0, 0); add(4'h9, 999, 0, 0, 0);
        add(4'hE, 998001, 0, 0, 0); add(4'hA, 998001, 0, 0, 1);
        add(4'h5, 998001, 0, 0, 1); add(4'hE, 998001, 0, 0, 1);
        add(4'hF, 0, 0, 0, 0);
        // Chaining at the -999 boundary is allowed
        add(4'h0, 0, 0, 0, 0);  add(4'hB, 0, 0, 0, 0);  add(4'h9, 9, 0, 0, 0);
        add(4'h9, 99, 0, 0, 0); add(4'h9, 999, 0, 0, 0); add(4'hE, -999, 0, 0, 0);
        add(4'hA, 0, 0, 0, 0);  add(4'h1, 1, 0, 0, 0);  add(4'hE, -998, 0, 0, 0);
        // Result 1000 cannot be chained
        add(4'hF, 0, 0, 0, 0);  add(4'h9, 9, 0, 0, 0);  add(4'h9, 99, 0, 0, 0);
        add(4'h9, 999, 0, 0, 0); add(4'hA, 0, 0, 0, 0); add(4'h1, 1, 0, 0, 0);
        add(4'hE, 1000, 0, 0, 0); add(4'hB, 1000, 0, 0, 1); add(4'hF, 0, 0, 0, 0);

        // Reset, with a key held during reset that must be ignored
        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h5;
        repeat (3) @(negedge clock);
        reset     = 1'b0;
        key_valid = 1'b0;
        @(negedge clock);
        check("rst_regA", int'(regA), 0);
        check("rst_regB", int'(regB), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_disp_value", int'(disp_value), 0);
        check("rst_disp_rem", int'(disp_remainder), 0);
        check("rst_disp_rem_valid", int'(disp_rem_valid), 0);
        check("rst_strobe", int'(computestrobe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);

        // Table-driven key sequence
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].key);
            settle();
            check($sformatf("vec%0d_disp", i), int'(disp_value), vecs[i].disp);
            check($sformatf("vec%0d_rem", i), int'(disp_remainder), vecs[i].rem);
            check($sformatf("vec%0d_remv", i), int'(disp_rem_valid), vecs[i].rv);
            check($sformatf("vec%0d_err", i), int'(err), vecs[i].er);
        end

        // 12 + 34: strobe timing and operands, result two cycles after strobe
        press(4'hF);
        s0 = strobe_count;
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hE);
        check("add_strobe_hi", int'(computestrobe), 1);
        check("add_busy_compute", int'(busy), 1);
        check("add_regA", int'(regA), 12);
        check("add_regB", int'(regB), 34);
        check("add_opcode", int'(opcode), 0);
        @(negedge clock);
        check("add_strobe_lo_wait", int'(computestrobe), 0);
        check("add_busy_wait", int'(busy), 1);
        @(negedge clock);
        check("add_disp_46", int'(disp_value), 46);
        check("add_busy_show", int'(busy), 0);
        check("add_strobe_count", strobe_count - s0, 1);
        check("add_cap_a", cap_a, 12);
        check("add_cap_b", cap_b, 34);
        check("add_cap_op", cap_op, 0);

        // 5-8 then chained *4
        press(4'hF);
        press(4'h5); press(4'hB); press(4'h8); press(4'hE); settle();
        check("chain_first", int'(disp_value), -3);
        press(4'hC); press(4'h4); press(4'hE); settle();
        check("chain_cap_a", cap_a, -3);
        check("chain_cap_b", cap_b, 4);
        check("chain_cap_op", cap_op, 2);
        check("chain_disp", int'(disp_value), -12);

        // Digit key during WAIT is dropped
        press(4'hF);
        press(4'h2); press(4'hC); press(4'h3); press(4'hE);
        press(4'h7);
        check("wait_key_ignored_disp", int'(disp_value), 6);
        check("wait_key_ignored_busy", int'(busy), 0);

        // Clear during WAIT discards the pending result
        press(4'hF);
        s0 = strobe_count;
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hE);
        press(4'hF);
        check("clr_wait_busy", int'(busy), 0);
        check("clr_wait_disp", int'(disp_value), 0);
        check("clr_wait_regA", int'(regA), 0);
        check("clr_wait_regB", int'(regB), 0);
        check("clr_wait_remv", int'(disp_rem_valid), 0);
        press(4'h5);
        check("clr_wait_entry", int'(disp_value), 5);
        check("clr_wait_strobes", strobe_count - s0, 1);

        // Reset mid-COMPUTE beats a coincident key
        press(4'hF);
        press(4'h4); press(4'hA); press(4'h4); press(4'hE);
        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h5;
        @(negedge clock);
        reset     = 1'b0;
        key_valid = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_strobe", int'(computestrobe), 0);
        check("rst_mid_disp", int'(disp_value), 0);
        check("rst_mid_regA", int'(regA), 0);
        check("rst_mid_regB", int'(regB), 0);

        // Divide by zero
        press(4'hF);
        s0 = strobe_count;
        press(4'h7); press(4'hD); press(4'h0); press(4'hE); settle();
        @(negedge clock);
`ifdef DIV0_ERR_EN
        check("div0_err", int'(err), 1);
        check("div0_no_strobe", strobe_count - s0, 0);
`else
        check("div0_err", int'(err), 0);
        check("div0_disp", int'(disp_value), 0);
        check("div0_remv", int'(disp_rem_valid), 0);
        check("div0_strobe", strobe_count - s0, 1);
`endif
        press(4'hF);
        check("div0_cleared", int'(err), 0);

        // Fourth digit ignored
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("four_digits", int'(disp_value), 123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
